// File: rtl/aes_128_iter_ctrl_pkg.sv
// Shared AES-128 constants, controller state encoding and GF(2^8) helpers.
// S-box is computed (inverse + affine) rather than tabulated.
package aes_128_iter_ctrl_pkg;

  localparam int         AES_ROUNDS = 10;
  localparam logic [7:0] RCON_INIT  = 8'h01;
  localparam logic [7:0] RCON_LAST  = 8'h36;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // b^254 == b^-1 in GF(2^8); zero maps to zero as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] b);
    logic [7:0] t;
    logic [7:0] r;
    t = b;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = gf_inv(b);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
             ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

endpackage

// File: rtl/aes_128_iter_ctrl_round.sv
// aes_round_128: one combinational AES-128 encipher round plus next round key.
// Byte k of the state is bits [127-8k -: 8]; column c holds bytes 4c..4c+3.
module aes_round_128
  import aes_128_iter_ctrl_pkg::*;
(
  input  logic [127:0] dat_in,
  input  logic [127:0] key_in,
  input  logic [7:0]   rconst,
  input  logic         skip_mix_col,
  output logic [127:0] dat_out,
  output logic [127:0] key_out
);

  logic [127:0] sb_v;
  logic [127:0] sr_v;
  logic [127:0] mc_v;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  k4, k5, k6, k7;
  logic [31:0]  key_tmp;

  always_comb begin
    sb_v = '0;
    for (int i = 0; i < 16; i++) begin
      sb_v[127-8*i -: 8] = sbox(dat_in[127-8*i -: 8]);
    end
  end

  // Row r of column c takes the byte from column (c+r) mod 4.
  always_comb begin
    sr_v = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr_v[127-8*(4*c+r) -: 8] = sb_v[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    mc_v = '0;
    for (int c = 0; c < 4; c++) begin
      mc_v[127-32*c -: 32] = mix_col(sr_v[127-32*c -: 32]);
    end
  end

  assign {w0, w1, w2, w3} = key_in;
  assign key_tmp = sub_word({w3[23:0], w3[31:24]}) ^ {rconst, 24'h000000};
  assign k4      = w0 ^ key_tmp;
  assign k5      = k4 ^ w1;
  assign k6      = k5 ^ w2;
  assign k7      = k6 ^ w3;
  assign key_out = {k4, k5, k6, k7};

  assign dat_out = (skip_mix_col ? sr_v : mc_v) ^ key_out;

endmodule

// File: rtl/aes_128_iter_ctrl.sv
// Iterative AES-128 encipher: one shared round engine, result 10 cycles after accept;
// result held in DONE until out_ready, in_ready low while a block is in flight.
module aes_128_iter_ctrl
  import aes_128_iter_ctrl_pkg::*;
#(
  parameter int BACK_TO_BACK = 1
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] dat_in,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] dat_out,
  output logic [127:0] inv_key,
  output logic         busy,
  output logic [3:0]   round
);

  state_e       state_q,   state_d;
  logic [127:0] blk_q,     blk_d;
  logic [127:0] key_q,     key_d;
  logic [3:0]   round_q,   round_d;
  logic [7:0]   rcon_q,    rcon_d;
  logic [127:0] dat_out_q, dat_out_d;
  logic [127:0] inv_key_q, inv_key_d;
  logic         rdy_en_q;

  logic [127:0] eng_dat;
  logic [127:0] eng_key;
  logic         last_round;
  logic         accept;

  assign last_round = (round_q == 4'(AES_ROUNDS));

  aes_round_128 u_round (
    .dat_in       (blk_q),
    .key_in       (key_q),
    .rconst       (rcon_q),
    .skip_mix_col (last_round),
    .dat_out      (eng_dat),
    .key_out      (eng_key)
  );

  // rdy_en_q keeps in_ready low throughout reset and for the release cycle.
  assign in_ready = rdy_en_q &
                    ((state_q == S_IDLE) |
                     ((BACK_TO_BACK != 0) & (state_q == S_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d   = state_q;
    blk_d     = blk_q;
    key_d     = key_q;
    round_d   = round_q;
    rcon_d    = rcon_q;
    dat_out_d = dat_out_q;
    inv_key_d = inv_key_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          blk_d   = dat_in ^ key;
          key_d   = key;
          round_d = 4'd1;
          rcon_d  = RCON_INIT;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        blk_d   = eng_dat;
        key_d   = eng_key;
        round_d = round_q + 4'd1;
        rcon_d  = xtime(rcon_q);
        if (last_round) begin
          dat_out_d = eng_dat;
          inv_key_d = eng_key;
          round_d   = 4'd0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        // accept here implies out_ready: the result retires on the load edge.
        if (accept) begin
          blk_d   = dat_in ^ key;
          key_d   = key;
          round_d = 4'd1;
          rcon_d  = RCON_INIT;
          state_d = S_ROUND;
        end else if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= S_IDLE;
      blk_q     <= '0;
      key_q     <= '0;
      round_q   <= 4'd0;
      rcon_q    <= RCON_INIT;
      dat_out_q <= '0;
      inv_key_q <= '0;
      rdy_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      blk_q     <= blk_d;
      key_q     <= key_d;
      round_q   <= round_d;
      rcon_q    <= rcon_d;
      dat_out_q <= dat_out_d;
      inv_key_q <= inv_key_d;
      rdy_en_q  <= 1'b1;
    end
  end

  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign round     = round_q;
  assign dat_out   = dat_out_q;
  assign inv_key   = inv_key_q;

  a_round_range: assert property (@(posedge clk) disable iff (!clr_n)
    (state_q == S_ROUND) |-> (round_q >= 4'd1 && round_q <= 4'(AES_ROUNDS)));

  a_rcon_last: assert property (@(posedge clk) disable iff (!clr_n)
    (state_q == S_ROUND && last_round) |-> (rcon_q == RCON_LAST));

  a_out_hold: assert property (@(posedge clk) disable iff (!clr_n)
    (state_q == S_DONE && !out_ready) |=> (state_q == S_DONE && $stable(dat_out_q)));

endmodule
